// File: rtl/rgb_din2sbit.sv
// Decodes a single-wire WS2812-style data line into serial-bit events (0, 1 or stream reset)
// by timing each high pulse and each low period after a two-flop synchronizer.
module rgb_din2sbit #(
    parameter int SAMPLE_TIME_CLKS  = 57,
    parameter int MIN_HIGH_CLKS     = 10,
    parameter int STREAM_RESET_CLKS = 4800,
    parameter int OUT_STROBE_CLKS   = 2,
    parameter int CNT_W             = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic in_din,
    output logic out_strobe,
    output logic out_sbit_value,
    output logic out_stream_reset,
    output logic out_glitch
);

    localparam logic [1:0] S_WAITLOW = 2'd0;
    localparam logic [1:0] S_LOW     = 2'd1;
    localparam logic [1:0] S_HIGH    = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam int WW = $clog2(OUT_STROBE_CLKS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] SAMPLE_C   = CNT_W'(SAMPLE_TIME_CLKS);
    localparam logic [CNT_W-1:0] MIN_HIGH_C = CNT_W'(MIN_HIGH_CLKS);
    // The stream reset fires on the clk whose low sample brings cnt up to the threshold.
    localparam logic [CNT_W-1:0] SRST_PRE_C = CNT_W'(STREAM_RESET_CLKS - 1);
    localparam logic [WW-1:0]    W_ONE      = WW'(1);
    localparam logic [WW-1:0]    W_LAST     = WW'(OUT_STROBE_CLKS);

    logic [1:0]       sync_reg;
    logic             din_s;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             armed_reg, armed_next;
    logic [WW-1:0]    width_cnt_reg;
    logic             emit, emit_val, emit_sr, glitch_next;

    assign din_s   = sync_reg[1];
    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], in_din};
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        armed_next  = armed_reg;
        emit        = 1'b0;
        emit_val    = 1'b0;
        emit_sr     = 1'b0;
        glitch_next = 1'b0;
        case (state_reg)
            S_WAITLOW: begin
                if (!din_s) begin
                    state_next = S_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            S_LOW: begin
                if (din_s) begin
                    state_next = S_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = cnt_inc;
                    if (armed_reg && cnt_reg == SRST_PRE_C) begin
                        emit       = 1'b1;
                        emit_sr    = 1'b1;
                        armed_next = 1'b0;
                    end
                end
            end
            S_HIGH: begin
                if (cnt_reg >= SAMPLE_C) begin
                    emit       = 1'b1;
                    emit_val   = 1'b1;
                    armed_next = 1'b1;
                    state_next = S_HOLD;
                end else if (!din_s) begin
                    state_next = S_LOW;
                    cnt_next   = CNT_ONE;
                    if (cnt_reg >= MIN_HIGH_C) begin
                        emit       = 1'b1;
                        armed_next = 1'b1;
                    end else begin
                        glitch_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                // S_HOLD: a line stuck high after a decoded 1 yields nothing further.
                if (!din_s) begin
                    state_next = S_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_WAITLOW;
            cnt_reg   <= '0;
            armed_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= armed_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_strobe       <= 1'b0;
            out_sbit_value   <= 1'b0;
            out_stream_reset <= 1'b0;
            out_glitch       <= 1'b0;
            width_cnt_reg    <= '0;
        end else begin
            out_glitch <= glitch_next;
            if (emit) begin
                out_strobe       <= 1'b1;
                out_sbit_value   <= emit_val;
                out_stream_reset <= emit_sr;
                width_cnt_reg    <= W_ONE;
            end else if (out_strobe) begin
                if (width_cnt_reg == W_LAST) begin
                    out_strobe       <= 1'b0;
                    out_sbit_value   <= 1'b0;
                    out_stream_reset <= 1'b0;
                    width_cnt_reg    <= '0;
                end else begin
                    width_cnt_reg <= width_cnt_reg + W_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_din2sbit.sv
// Directed bench for rgb_din2sbit: three instances (strobe widths 2, 1, 4) share one data line;
// a negedge monitor logs strobe events, the main sequence checks them against hand-derived timing.
module tb_rgb_din2sbit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_din;
    logic [2:0] strobe_w, val_w, sr_w, glitch_w;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int SW = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
        rgb_din2sbit #(.OUT_STROBE_CLKS(SW)) u_dut (
            .clk              (clk),
            .rst              (rst),
            .in_din           (in_din),
            .out_strobe       (strobe_w[gi]),
            .out_sbit_value   (val_w[gi]),
            .out_stream_reset (sr_w[gi]),
            .out_glitch       (glitch_w[gi])
        );
    end

    // Event log per instance
    int   ev_n[3];
    int   ev_start[3][64];
    logic ev_val[3][64];
    logic ev_sr[3][64];
    int   ev_width[3][64];
    int   field_err[3];
    int   gl_pulses[3];
    int   gl_cycles[3];
    int   run_w[3];
    logic prev_s[3], prev_v[3], prev_r[3], prev_g[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            ev_n[i] = 0; field_err[i] = 0; gl_pulses[i] = 0; gl_cycles[i] = 0; run_w[i] = 0;
            prev_s[i] = 1'b0; prev_v[i] = 1'b0; prev_r[i] = 1'b0; prev_g[i] = 1'b0;
            for (int k = 0; k < 64; k++) begin
                ev_start[i][k] = -1; ev_val[i][k] = 1'bx; ev_sr[i][k] = 1'bx; ev_width[i][k] = -1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (strobe_w[i] === 1'b1) begin
                if (!prev_s[i]) begin
                    if (ev_n[i] < 64) begin
                        ev_start[i][ev_n[i]] = cyc;
                        ev_val[i][ev_n[i]]   = val_w[i];
                        ev_sr[i][ev_n[i]]    = sr_w[i];
                    end
                    ev_n[i]++;
                    run_w[i] = 1;
                end else begin
                    run_w[i]++;
                    if (val_w[i] !== prev_v[i] || sr_w[i] !== prev_r[i]) field_err[i]++;
                end
            end else begin
                if (prev_s[i] && ev_n[i] <= 64) ev_width[i][ev_n[i]-1] = run_w[i];
                if (val_w[i] !== 1'b0 || sr_w[i] !== 1'b0) field_err[i]++;
            end
            if (glitch_w[i] === 1'b1) begin
                gl_cycles[i]++;
                if (!prev_g[i]) gl_pulses[i]++;
            end
            prev_s[i] = (strobe_w[i] === 1'b1);
            prev_v[i] = val_w[i];
            prev_r[i] = sr_w[i];
            prev_g[i] = (glitch_w[i] === 1'b1);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_event(input string tag, input int idx, input int t_ref, input int lat,
                               input int val, input int sr);
        check({tag, "_lat"}, ev_start[0][idx] - t_ref, lat);
        check({tag, "_val"}, int'(ev_val[0][idx]), val);
        check({tag, "_sr"},  int'(ev_sr[0][idx]), sr);
    endtask

    int t0, f0, g0, gc0;
    int rise_t[24];

    initial begin
        rst    = 1'b1;
        in_din = 1'b0;
        idle(5);
        check("reset_outputs", int'({strobe_w, val_w, sr_w, glitch_w}), 0);

        // Line held low from reset release: one stream reset
        rst = 1'b0;
        t0  = cyc;
        idle(5000);
        check("t1_count", ev_n[0], 1);
        check_event("t1_srst", 0, t0, 4802, 0, 1);
        check("t1_width2", ev_width[0][0], 2);
        check("t1_width1", ev_width[1][0], 1);
        check("t1_width4", ev_width[2][0], 4);

        // 24 full-width pulses decode as 1
        for (int k = 0; k < 24; k++) begin
            rise_t[k] = cyc;
            in_din = 1'b1;
            idle(77);
            in_din = 1'b0;
            idle(43);
        end
        check("t2_count", ev_n[0], 25);
        for (int k = 0; k < 24; k++) begin
            check_event($sformatf("t2_bit%0d", k), k + 1, rise_t[k], 60, 1, 0);
        end

        // Short pulse decodes as 0, then a long low gives a stream reset
        t0 = cyc;
        in_din = 1'b1;
        idle(38);
        in_din = 1'b0;
        f0 = cyc;
        idle(5000);
        check("t3_count", ev_n[0], 27);
        check_event("t3_bit0", 25, t0, 41, 0, 0);
        check_event("t3_srst", 26, f0, 4802, 0, 1);

        // Glitch pulse mid-low; unarmed long low must stay silent
        g0  = gl_pulses[0];
        gc0 = gl_cycles[0];
        in_din = 1'b1;
        idle(5);
        in_din = 1'b0;
        idle(10000);
        check("t4_glitch_pulses", gl_pulses[0] - g0, 1);
        check("t4_glitch_width", gl_cycles[0] - gc0, 1);
        check("t4_no_strobe", ev_n[0], 27);

        // Reset in the middle of a high pulse
        in_din = 1'b1;
        idle(30);
        rst = 1'b1;
        idle(2);
        check("t5_rst_outputs", int'({strobe_w, val_w, sr_w, glitch_w}), 0);
        rst = 1'b0;
        idle(45);
        in_din = 1'b0;
        idle(43);
        check("t5_partial_dropped", ev_n[0], 27);
        t0 = cyc;
        in_din = 1'b1;
        idle(77);
        in_din = 1'b0;
        idle(43);
        check("t5_count", ev_n[0], 28);
        check_event("t5_bit1", 27, t0, 60, 1, 0);

        // Strobe widths and field hygiene on all instances
        check("t6_count_w1", ev_n[1], 28);
        check("t6_count_w4", ev_n[2], 28);
        for (int k = 0; k < 28; k++) begin
            check($sformatf("t6_w1_ev%0d", k), ev_width[1][k], 1);
            check($sformatf("t6_w4_ev%0d", k), ev_width[2][k], 4);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("field_hygiene_%0d", i), field_err[i], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
